// File: rtl/irq_dispatch.sv
// irq_dispatch -- hands one pending interrupt at a time from the interrupt
// controller to the CPU and tracks per-source dispatch statistics.
//
// Ports:
//   clk, rst                 single clock, synchronous active-high reset
//   irq_in, src_in,          pending flag, source index and ISR address
//   isr_addr_in              from the interrupt controller
//   iack                     one-cycle pulse clearing the selected source
//   cpu_int, cpu_vector      request and latched ISR address for the CPU
//   cpu_int_ack              CPU has taken the vector
//   cs, input_addr,          register bus (bits [3:2] of the address are
//   write_data,              decoded: 0 MASK, 1 STATUS, 2 COUNT, 3 CTRL)
//   write_enable, read_data
module irq_dispatch #(
  parameter int ACK_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        irq_in,
  input  logic [1:0]  src_in,
  input  logic [31:0] isr_addr_in,
  output logic        iack,
  output logic        cpu_int,
  output logic [31:0] cpu_vector,
  input  logic        cpu_int_ack,
  input  logic        cs,
  input  logic [31:0] input_addr,
  input  logic [31:0] write_data,
  input  logic        write_enable,
  output logic [31:0] read_data
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_REQ     = 3'd1,
    ST_ACK     = 3'd2,
    ST_SERVICE = 3'd3,
    ST_DROP    = 3'd4,
    ST_GUARD   = 3'd5
  } state_e;

  // Last value of the REQ cycle counter before the request is abandoned.
  localparam logic [7:0] TO_LAST = 8'(ACK_TIMEOUT - 1);

  // Saturating 8-bit increment for the dispatch counters.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    if (v == 8'hFF) begin
      return 8'hFF;
    end else begin
      return v + 8'd1;
    end
  endfunction

  state_e           state_q, state_d;
  logic [7:0]       to_cnt_q, to_cnt_d;
  logic [1:0]       act_src_q, act_src_d;
  logic [31:0]      vector_q, vector_d;
  logic [3:0]       mask_q, mask_d;
  logic [3:0][7:0]  cnt_q, cnt_d;
  logic             to_flag_q, to_flag_d;
  logic             cpu_int_q, iack_q;

  logic             wr_s, wr_mask_s, wr_ctrl_s;
  logic             eoi_s, clr_cnt_s, clr_to_s, to_set_s, busy_s;
  logic [31:0]      read_s;
  logic             unused_bits_s;

  assign wr_s      = cs & write_enable;
  assign wr_mask_s = wr_s & (input_addr[3:2] == 2'd0);
  assign wr_ctrl_s = wr_s & (input_addr[3:2] == 2'd3);
  assign eoi_s     = wr_ctrl_s & write_data[0];
  assign clr_cnt_s = wr_ctrl_s & write_data[1];
  assign clr_to_s  = wr_ctrl_s & write_data[2];
  assign busy_s    = (state_q == ST_REQ) | (state_q == ST_ACK) | (state_q == ST_SERVICE);

  // Address and data bits outside the register map carry no meaning here.
  assign unused_bits_s = ^{input_addr[31:4], input_addr[1:0], write_data[31:4]};

  // Dispatch FSM next state plus the source/vector/timeout bookkeeping.
  always_comb begin
    state_d   = state_q;
    to_cnt_d  = to_cnt_q;
    act_src_d = act_src_q;
    vector_d  = vector_q;
    to_set_s  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (irq_in) begin
          if (mask_q[src_in]) begin
            state_d = ST_DROP;
          end else begin
            state_d   = ST_REQ;
            act_src_d = src_in;
            vector_d  = isr_addr_in;
            to_cnt_d  = 8'd0;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        // An ack arriving on the last allowed cycle still wins.
        if (cpu_int_ack) begin
          state_d = ST_ACK;
        end else if (to_cnt_q == TO_LAST) begin
          // No iack: the source stays pending and is retried from IDLE.
          state_d  = ST_IDLE;
          to_set_s = 1'b1;
          to_cnt_d = 8'd0;
        end else begin
          to_cnt_d = to_cnt_q + 8'd1;
        end
      end
      ST_ACK:     state_d = ST_SERVICE;
      ST_SERVICE: begin
        if (eoi_s) begin
          state_d = ST_GUARD;
        end else begin
          state_d = ST_SERVICE;
        end
      end
      ST_DROP:    state_d = ST_GUARD;
      ST_GUARD:   state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Per-source counters, mask and sticky timeout flag; clears win over updates.
  always_comb begin
    cnt_d = cnt_q;
    for (int i = 0; i < 4; i++) begin
      if (clr_cnt_s) begin
        cnt_d[i] = 8'd0;
      end else if ((state_q == ST_ACK) && (act_src_q == 2'(i))) begin
        cnt_d[i] = sat_inc8(cnt_q[i]);
      end else begin
        cnt_d[i] = cnt_q[i];
      end
    end
    if (wr_mask_s) begin
      mask_d = write_data[3:0];
    end else begin
      mask_d = mask_q;
    end
    if (to_set_s) begin
      to_flag_d = 1'b1;
    end else if (clr_to_s) begin
      to_flag_d = 1'b0;
    end else begin
      to_flag_d = to_flag_q;
    end
  end

  // State and register update; outputs are registered from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      to_cnt_q  <= 8'd0;
      act_src_q <= 2'd0;
      vector_q  <= 32'd0;
      mask_q    <= 4'd0;
      cnt_q     <= '0;
      to_flag_q <= 1'b0;
      cpu_int_q <= 1'b0;
      iack_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      to_cnt_q  <= to_cnt_d;
      act_src_q <= act_src_d;
      vector_q  <= vector_d;
      mask_q    <= mask_d;
      cnt_q     <= cnt_d;
      to_flag_q <= to_flag_d;
      cpu_int_q <= (state_d == ST_REQ);
      iack_q    <= (state_d == ST_ACK) | (state_d == ST_DROP);
    end
  end

  // Register read mux; the bus reads zero when not selected.
  always_comb begin
    read_s = 32'd0;
    if (cs) begin
      case (input_addr[3:2])
        2'd0:    read_s = {28'd0, mask_q};
        2'd1:    read_s = {23'd0, to_flag_q, 2'b00, act_src_q, busy_s, state_q};
        2'd2:    read_s = cnt_q;
        default: read_s = 32'd0;
      endcase
    end else begin
      read_s = 32'd0;
    end
  end

  assign read_data  = read_s;
  assign cpu_int    = cpu_int_q;
  assign iack       = iack_q;
  assign cpu_vector = vector_q;

endmodule

// File: tb/tb_irq_dispatch.sv
module tb_irq_dispatch;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst, irq_in, iack, cpu_int, cpu_int_ack, cs, write_enable;
  logic [1:0]  src_in;
  logic [31:0] isr_addr_in, cpu_vector, input_addr, write_data, read_data;

  int checks = 0;
  int failures = 0;

  // Reference model state for the randomized dispatch run.
  int          exp_cnt [4];
  logic        exp_to;
  logic [31:0] exp_vec;

  always #5 clk = ~clk;

  irq_dispatch #(.ACK_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .irq_in(irq_in), .src_in(src_in),
    .isr_addr_in(isr_addr_in), .iack(iack), .cpu_int(cpu_int),
    .cpu_vector(cpu_vector), .cpu_int_ack(cpu_int_ack), .cs(cs),
    .input_addr(input_addr), .write_data(write_data),
    .write_enable(write_enable), .read_data(read_data)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    cs = 1'b1; write_enable = 1'b1; input_addr = {28'd0, a, 2'b00}; write_data = d;
    tick();
    cs = 1'b0; write_enable = 1'b0; write_data = 32'd0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    cs = 1'b1; write_enable = 1'b0; input_addr = {28'd0, a, 2'b00};
    #1;
    d = read_data;
    cs = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] r;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    checks++; if (cpu_int !== 1'b0) begin failures++; $display("FAIL reset_cpu_int: got %b expected 0", cpu_int); end
    checks++; if (iack !== 1'b0) begin failures++; $display("FAIL reset_iack: got %b expected 0", iack); end
    checks++; if (cpu_vector !== 32'd0) begin failures++; $display("FAIL reset_vector: got %h expected 0", cpu_vector); end
    bus_read(2'd1, r);
    checks++; if (r !== 32'd0) begin failures++; $display("FAIL reset_status: got %h expected 0", r); end
    bus_read(2'd0, r);
    checks++; if (r !== 32'd0) begin failures++; $display("FAIL reset_mask: got %h expected 0", r); end
    bus_read(2'd2, r);
    checks++; if (r !== 32'd0) begin failures++; $display("FAIL reset_count: got %h expected 0", r); end
  endtask

  task automatic test_normal_dispatch();
    logic [31:0] r;
    irq_in = 1'b1; src_in = 2'd2; isr_addr_in = 32'h0000_0200;
    tick();
    checks++; if (cpu_int !== 1'b1) begin failures++; $display("FAIL nd_cpu_int: got %b expected 1", cpu_int); end
    checks++; if (cpu_vector !== 32'h200) begin failures++; $display("FAIL nd_vector: got %h expected 00000200", cpu_vector); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (cpu_int !== 1'b1 || iack !== 1'b0) begin failures++; $display("FAIL nd_req_hold: got cpu_int=%b iack=%b expected 1/0", cpu_int, iack); end
    end
    // Ack on the final allowed REQ cycle must beat the timeout.
    cpu_int_ack = 1'b1;
    tick();
    cpu_int_ack = 1'b0; irq_in = 1'b0;
    checks++; if (iack !== 1'b1 || cpu_int !== 1'b0) begin failures++; $display("FAIL nd_ack: got iack=%b cpu_int=%b expected 1/0", iack, cpu_int); end
    tick();
    checks++; if (iack !== 1'b0) begin failures++; $display("FAIL nd_iack_width: got %b expected 0", iack); end
    bus_read(2'd1, r);
    checks++; if (r !== 32'h0000_002B) begin failures++; $display("FAIL nd_status_service: got %h expected 0000002b", r); end
    bus_read(2'd2, r);
    checks++; if (r !== 32'h0001_0000) begin failures++; $display("FAIL nd_count: got %h expected 00010000", r); end
    cs = 1'b0; input_addr = 32'h4; #1;
    checks++; if (read_data !== 32'd0) begin failures++; $display("FAIL nd_cs_low_read: got %h expected 0", read_data); end
    tick(); tick();
    bus_read(2'd1, r);
    checks++; if (r[3:0] !== 4'hB) begin failures++; $display("FAIL nd_still_busy: got %h expected b", r[3:0]); end
    bus_write(2'd3, 32'h1);
    bus_read(2'd1, r);
    checks++; if (r !== 32'h0000_0025) begin failures++; $display("FAIL nd_guard: got %h expected 00000025", r); end
    tick();
    bus_read(2'd1, r);
    checks++; if (r !== 32'h0000_0020) begin failures++; $display("FAIL nd_idle: got %h expected 00000020", r); end
  endtask

  task automatic test_mask_drop();
    logic [31:0] r;
    int pulses, highs;
    pulses = 0; highs = 0;
    bus_write(2'd0, 32'h2);
    bus_read(2'd0, r);
    checks++; if (r !== 32'h2) begin failures++; $display("FAIL md_mask_rb: got %h expected 2", r); end
    irq_in = 1'b1; src_in = 2'd1; isr_addr_in = 32'h0000_0100;
    tick();
    irq_in = 1'b0;
    bus_read(2'd1, r);
    checks++; if (r[2:0] !== 3'd4) begin failures++; $display("FAIL md_drop_state: got %0d expected 4", r[2:0]); end
    pulses += int'(iack); highs += int'(cpu_int);
    for (int i = 0; i < 4; i++) begin
      tick();
      pulses += int'(iack); highs += int'(cpu_int);
    end
    checks++; if (pulses != 1) begin failures++; $display("FAIL md_iack_pulses: got %0d expected 1", pulses); end
    checks++; if (highs != 0) begin failures++; $display("FAIL md_cpu_int: got %0d high cycles expected 0", highs); end
    bus_read(2'd2, r);
    checks++; if (r !== 32'h0001_0000) begin failures++; $display("FAIL md_count: got %h expected 00010000", r); end
    bus_write(2'd0, 32'h0);
  endtask

  task automatic test_timeout();
    logic [31:0] r;
    logic exp_ci;
    irq_in = 1'b1; src_in = 2'd3; isr_addr_in = 32'h0000_0300;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i == 5) irq_in = 1'b0;
      exp_ci = (i < 4) || (i >= 5 && i < 9);
      checks++; if (cpu_int !== exp_ci || iack !== 1'b0) begin failures++; $display("FAIL to_cycle%0d: got cpu_int=%b iack=%b expected %b/0", i, cpu_int, iack, exp_ci); end
      if (i == 4) begin
        bus_read(2'd1, r);
        checks++; if (r[8] !== 1'b1 || r[2:0] !== 3'd0) begin failures++; $display("FAIL to_status: got %h expected to_flag=1 state=0", r); end
      end
    end
    checks++; if (cpu_vector !== 32'h300) begin failures++; $display("FAIL to_vector: got %h expected 00000300", cpu_vector); end
    bus_write(2'd3, 32'h4);
    bus_read(2'd1, r);
    checks++; if (r[8] !== 1'b0) begin failures++; $display("FAIL to_clear: got %b expected 0", r[8]); end
  endtask

  task automatic dispatch_src0();
    irq_in = 1'b1; src_in = 2'd0; isr_addr_in = 32'h0;
    tick();
    cpu_int_ack = 1'b1; irq_in = 1'b0;
    tick();
    cpu_int_ack = 1'b0;
    tick();
    bus_write(2'd3, 32'h1);
    tick();
  endtask

  task automatic test_saturation();
    logic [31:0] r;
    for (int i = 0; i < 255; i++) dispatch_src0();
    bus_read(2'd2, r);
    checks++; if (r[7:0] !== 8'd255) begin failures++; $display("FAIL sat_255: got %0d expected 255", r[7:0]); end
    dispatch_src0();
    bus_read(2'd2, r);
    checks++; if (r[7:0] !== 8'd255) begin failures++; $display("FAIL sat_hold: got %0d expected 255", r[7:0]); end
    irq_in = 1'b1; src_in = 2'd0;
    tick();
    cpu_int_ack = 1'b1; irq_in = 1'b0;
    tick();
    cpu_int_ack = 1'b0;
    checks++; if (iack !== 1'b1) begin failures++; $display("FAIL sat_ack: got iack=%b expected 1", iack); end
    bus_write(2'd3, 32'h2);
    bus_read(2'd2, r);
    checks++; if (r !== 32'd0) begin failures++; $display("FAIL sat_clear: got %h expected 0", r); end
    bus_write(2'd3, 32'h1);
    tick();
  endtask

  task automatic test_stray_eoi_reset();
    logic [31:0] r;
    bus_write(2'd3, 32'h1);
    bus_read(2'd1, r);
    checks++; if (r[3:0] !== 4'd0) begin failures++; $display("FAIL se_stray_eoi: got %h expected 0", r[3:0]); end
    bus_write(2'd0, 32'h8);
    irq_in = 1'b1; src_in = 2'd1; isr_addr_in = 32'hABCD_0100;
    tick();
    cpu_int_ack = 1'b1; irq_in = 1'b0;
    tick();
    cpu_int_ack = 1'b0;
    tick();
    bus_read(2'd1, r);
    checks++; if (r !== 32'h0000_001B) begin failures++; $display("FAIL se_service: got %h expected 0000001b", r); end
    rst = 1'b1;
    tick();
    checks++; if (iack !== 1'b0 || cpu_int !== 1'b0 || cpu_vector !== 32'd0) begin failures++; $display("FAIL se_rst_outputs: got iack=%b cpu_int=%b vec=%h expected 0/0/0", iack, cpu_int, cpu_vector); end
    bus_read(2'd1, r);
    checks++; if (r !== 32'd0) begin failures++; $display("FAIL se_rst_status: got %h expected 0", r); end
    bus_read(2'd0, r);
    checks++; if (r !== 32'd0) begin failures++; $display("FAIL se_rst_mask: got %h expected 0", r); end
    bus_read(2'd2, r);
    checks++; if (r !== 32'd0) begin failures++; $display("FAIL se_rst_count: got %h expected 0", r); end
    rst = 1'b0;
    tick();
    checks++; if (iack !== 1'b0) begin failures++; $display("FAIL se_post_rst_iack: got %b expected 0", iack); end
  endtask

  task automatic test_random();
    logic [31:0] r, a;
    logic [3:0]  m;
    logic [1:0]  s;
    int          d;
    for (int k = 0; k < 4; k++) exp_cnt[k] = 0;
    exp_to = 1'b0; exp_vec = 32'd0;
    for (int it = 0; it < 40; it++) begin
      m = 4'($urandom_range(0, 15));
      s = 2'($urandom_range(0, 3));
      a = $urandom;
      d = $urandom_range(0, 5);
      bus_write(2'd0, {28'd0, m});
      if ($urandom_range(0, 7) == 0) begin
        bus_write(2'd3, 32'h2);
        for (int k = 0; k < 4; k++) exp_cnt[k] = 0;
      end
      irq_in = 1'b1; src_in = s; isr_addr_in = a;
      tick();
      if (m[s]) begin
        checks++; if (iack !== 1'b1 || cpu_int !== 1'b0) begin failures++; $display("FAIL rnd_drop it%0d: got iack=%b cpu_int=%b expected 1/0", it, iack, cpu_int); end
        irq_in = 1'b0;
        tick(); tick();
      end else begin
        exp_vec = a;
        checks++; if (cpu_int !== 1'b1 || cpu_vector !== a) begin failures++; $display("FAIL rnd_req it%0d: got cpu_int=%b vec=%h expected 1/%h", it, cpu_int, cpu_vector, a); end
        if (d < TO) begin
          // A mask change mid-dispatch must not abort this dispatch.
          if (d > 0) begin
            bus_write(2'd0, 32'hF);
            repeat (d - 1) tick();
          end
          cpu_int_ack = 1'b1; irq_in = 1'b0;
          tick();
          cpu_int_ack = 1'b0;
          checks++; if (iack !== 1'b1) begin failures++; $display("FAIL rnd_ack it%0d: got iack=%b expected 1", it, iack); end
          tick();
          bus_write(2'd3, 32'h1);
          tick();
          exp_cnt[s] = (exp_cnt[s] >= 255) ? 255 : exp_cnt[s] + 1;
        end else begin
          irq_in = 1'b0;
          repeat (TO) tick();
          checks++; if (cpu_int !== 1'b0 || iack !== 1'b0) begin failures++; $display("FAIL rnd_timeout it%0d: got cpu_int=%b iack=%b expected 0/0", it, cpu_int, iack); end
          exp_to = 1'b1;
        end
      end
      bus_read(2'd2, r);
      checks++; if (r !== {8'(exp_cnt[3]), 8'(exp_cnt[2]), 8'(exp_cnt[1]), 8'(exp_cnt[0])}) begin failures++; $display("FAIL rnd_count it%0d: got %h", it, r); end
      bus_read(2'd1, r);
      checks++; if (r[8] !== exp_to || r[2:0] !== 3'd0) begin failures++; $display("FAIL rnd_status it%0d: got %h expected to_flag=%b state=0", it, r, exp_to); end
      checks++; if (cpu_vector !== exp_vec) begin failures++; $display("FAIL rnd_vec_hold it%0d: got %h expected %h", it, cpu_vector, exp_vec); end
    end
  endtask

  initial begin
    rst = 1'b1; irq_in = 1'b0; src_in = 2'd0; isr_addr_in = 32'd0;
    cpu_int_ack = 1'b0; cs = 1'b0; input_addr = 32'd0; write_data = 32'd0;
    write_enable = 1'b0;
    @(negedge clk);
    test_reset();
    test_normal_dispatch();
    test_mask_drop();
    test_timeout();
    test_saturation();
    test_stray_eoi_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/irq_dispatch.md
IRQ_DISPATCH -- requirements
Module: irq_dispatch

Interface
REQ-001 SHALL have parameter ACK_TIMEOUT, default 255: cycles spent in REQ without cpu_int_ack before abandon; legal range 1..255.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port irq_in  input  1  pending-interrupt flag from the interrupt controller.
REQ-005 SHALL have port src_in  input  2  priority-encoded source index from the interrupt controller.
REQ-006 SHALL have port isr_addr_in  input  32  ISR address for src_in.
REQ-007 SHALL have port iack  output  1  one-cycle pulse that clears the selected source in the interrupt controller.
REQ-008 SHALL have port cpu_int  output  1  interrupt request to the CPU.
REQ-009 SHALL have port cpu_vector  output  32  latched ISR address presented to the CPU.
REQ-010 SHALL have port cpu_int_ack  input  1  CPU has taken the vector.
REQ-011 SHALL have port cs  input  1  register-bus chip select.
REQ-012 SHALL have port input_addr  input  32  bus address; only bits [3:2] are decoded.
REQ-013 SHALL have port write_data  input  32  bus write data.
REQ-014 SHALL have port write_enable  input  1  bus write strobe, qualified by cs.
REQ-015 SHALL have port read_data  output  32  combinational read of the addressed register.

Function
REQ-016 SHALL implement the FSM states IDLE, REQ, ACK, SERVICE, DROP and GUARD.
REQ-017 SHALL, in IDLE with irq_in=1 and mask[src_in]=0, latch src_in into act_src and isr_addr_in into cpu_vector, and go to REQ.
REQ-018 SHALL, in IDLE with irq_in=1 and mask[src_in]=1, go to DROP.
REQ-019 SHALL, in DROP, assert iack for exactly that cycle and go to GUARD; the masked interrupt is discarded.
REQ-020 SHALL, in REQ, hold cpu_int=1 and count cycles from 0; cpu_int_ack=1 moves the FSM to ACK.
REQ-021 SHALL, in REQ, when the count reaches ACK_TIMEOUT with no ack, go to IDLE without iack, set sticky flag to_flag, and leave the source pending for retry.
REQ-022 SHALL, when cpu_int_ack and timeout expiry occur in the same cycle, give priority to the ack.
REQ-023 SHALL, in ACK, pulse iack for one cycle, increment cnt[act_src] (8-bit, saturates at 255) and go to SERVICE.
REQ-024 SHALL, in SERVICE, hold cpu_int=0 and wait for EOI, then go to GUARD.
REQ-025 SHALL, in GUARD, ignore irq_in for one cycle, then go to IDLE; this lets the controller's status flop clear.
REQ-026 SHALL drive cpu_int=1 only in REQ and iack=1 only in ACK or DROP.
REQ-027 SHALL drive cpu_vector to hold its last latched value outside REQ.
REQ-028 SHALL decode the register map on input_addr[3:2]:
- 0 = MASK: rw, bits [3:0], 1 = masked.
- 1 = STATUS: ro, {to_flag[8], act_src[5:4], busy[3], state[2:0]}, busy=1 in REQ, ACK or SERVICE. State encoding: IDLE=0, REQ=1, ACK=2, SERVICE=3, DROP=4, GUARD=5.
- 2 = COUNT: ro, {cnt3, cnt2, cnt1, cnt0}, 8 bits each.
- 3 = CTRL: write-only, reads as 0. Bit0 = EOI, bit1 = clear counters, bit2 = clear to_flag.
REQ-029 SHALL accept a write only when cs=1 and write_enable=1; the write takes effect at the next edge.
REQ-030 SHALL ignore an EOI write unless the FSM is in SERVICE.
REQ-031 SHALL, on a counter clear in the same cycle as an ACK increment, give priority to the clear.
REQ-032 SHALL apply a MASK write during REQ, ACK or SERVICE to later dispatches only, without aborting the current one.
REQ-033 SHALL drive read_data=0 when cs=0.

Reset
REQ-034 SHALL, while rst=1 at a clock edge, force state=IDLE and clear to zero: cpu_int, iack, cpu_vector, act_src, mask, all cnt, to_flag and the timeout counter.
REQ-035 SHALL, on rst asserted mid-operation in any state, abandon the operation and issue no iack pulse.

Verification
REQ-036 SHALL have a bench scenario for normal dispatch:
- Stimulus: irq_in=1, src_in=2, isr_addr_in=0x0000_0200; ack 3 cycles after cpu_int rises.
- Response: cpu_int=1 with cpu_vector=0x200; one-cycle iack; cnt2=1; STATUS busy until a CTRL write of 0x1; then GUARD, then IDLE.
REQ-037 SHALL have a bench scenario for mask drop:
- Stimulus: MASK=0x2, irq_in=1, src_in=1.
- Response: cpu_int stays 0; one iack pulse; cnt1=0.
REQ-038 SHALL have a bench scenario for timeout: ACK_TIMEOUT=4 with no ack; cpu_int high for 4 cycles, then low; STATUS to_flag=1; no iack; re-dispatch of the same source in the next IDLE cycle.
REQ-039 SHALL have a bench scenario for saturation and clear: 256 completed dispatches of src 0 give cnt0=255; a CTRL write of 0x2 coincident with an ACK gives cnt0=0.
REQ-040 SHALL have a bench scenario for a stray EOI and reset during SERVICE: a CTRL write of 0x1 in IDLE leaves the state unchanged; rst=1 during SERVICE gives state=0 with all registers at zero on the next cycle.
